recip_scale: RTL and testbench

- Sequencer that computes q = num / den in signed Q(W-F).F fixed point.
- Accepts (num, den) pairs on a valid/ready input and launches the team's reciprocal unit with den.
- Waits for its done pulse, multiplies num by the returned reciprocal with rounding and saturation, and presents the result plus a status code on a valid/ready output.
- Sits between the watchdog rate/ratio logic and the reciprocal unit; it is that unit's only driver and consumer.

---
 rtl/recip_scale.sv | 203 ++++++++++++++++++++
 tb/tb_recip_scale.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/recip_scale.sv
// -----------------------------------------------------------------------------
// recip_scale
//   Fixed-point divider sequencer: q = num / den in signed Q(W-F).F.
//   A (num, den) pair is accepted on a valid/ready input. den is handed to the
//   shared reciprocal unit (rc_*), and the returned unsigned reciprocal is
//   multiplied by num. The product is rounded half toward +inf and saturated.
//   The quotient and a status code are presented on a valid/ready output.
//   Only one request is in flight at a time.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_num, in_den signed QF operands
//   rc_start            one-cycle start pulse to the reciprocal unit
//   rc_x                reciprocal operand (registered den, stable while busy)
//   rc_done             one-cycle completion pulse from the reciprocal unit
//   rc_inv              unsigned QF reciprocal, valid with rc_done
//   rc_invalid          operand rejected by the unit, valid with rc_done
//   out_valid/out_ready result handshake; out_q signed QF quotient
//   out_status          0 OK, 1 bad denominator, 2 timeout, 3 saturated
// -----------------------------------------------------------------------------
module recip_scale #(
  parameter int W           = 32,
  parameter int F           = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_den,
  output logic         rc_start,
  output logic [W-1:0] rc_x,
  input  logic         rc_done,
  input  logic [W-1:0] rc_inv,
  input  logic         rc_invalid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [1:0]   out_status
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int PW = 2 * W + 1;

  // Saturation bounds and rounding constant, sign-extended to product width.
  localparam logic signed [PW-1:0] Q_MAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW-1:0] Q_MIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};
  localparam logic signed [PW-1:0] HALF  = {{(PW - F){1'b0}}, 1'b1, {(F - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_MUL,
    S_OUT
  } state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BAD_DEN = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_SAT     = 2'd3;

  state_e         state_q, state_d;
  logic [W-1:0]   num_q, num_d;
  logic [W-1:0]   den_q, den_d;
  logic [W-1:0]   inv_q, inv_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [W-1:0]   res_q, res_d;
  logic [1:0]     status_q, status_d;

  // Datapath for the MUL state.
  logic signed [PW-1:0] num_ext;
  logic signed [PW-1:0] inv_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_rnd;
  logic signed [PW-1:0] rounded;
  logic [W-1:0]         mul_q;
  logic [1:0]           mul_status;
  logic                 den_nonpos;
  logic                 timer_last;

  // Handshake strobes are pure state decodes, so they take their reset values
  // as soon as the state register is cleared.
  assign in_ready   = (state_q == S_IDLE);
  assign rc_start   = (state_q == S_START);
  assign out_valid  = (state_q == S_OUT);
  assign rc_x       = den_q;
  assign out_q      = res_q;
  assign out_status = status_q;

  assign den_nonpos = in_den[W-1] | (in_den == '0);
  assign timer_last = (timer_q == TW'(TIMEOUT_CYC - 1));

  // num is signed; the reciprocal is unsigned, so it gets a zero MSB before the
  // signed multiply. All operands are widened to the full product width.
  always_comb begin
    num_ext  = {{(W + 1){num_q[W-1]}}, num_q};
    inv_ext  = {{(W + 1){1'b0}}, inv_q};
    prod     = num_ext * inv_ext;
    prod_rnd = prod + HALF;
    rounded  = prod_rnd >>> F;
    if (rounded > Q_MAX) begin
      mul_q      = {1'b0, {(W - 1){1'b1}}};
      mul_status = ST_SAT;
    end else if (rounded < Q_MIN) begin
      mul_q      = {1'b1, {(W - 1){1'b0}}};
      mul_status = ST_SAT;
    end else begin
      mul_q      = rounded[W-1:0];
      mul_status = ST_OK;
    end
  end

  always_comb begin
    // NOTE: every next-state variable is given its hold value first so that no
    // path through the case statement leaves one unassigned (no latches).
    state_d  = state_q;
    num_d    = num_q;
    den_d    = den_q;
    inv_d    = inv_q;
    timer_d  = timer_q;
    res_d    = res_q;
    status_d = status_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          num_d = in_num;
          den_d = in_den;
          if (den_nonpos) begin
            // The reciprocal unit cannot handle this; answer directly.
            res_d    = '0;
            status_d = ST_BAD_DEN;
            state_d  = S_OUT;
          end else begin
            state_d = S_START;
          end
        end
      end

      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A completion on the last allowed cycle still counts as a result.
        if (rc_done) begin
          if (rc_invalid) begin
            res_d    = '0;
            status_d = ST_BAD_DEN;
            state_d  = S_OUT;
          end else begin
            inv_d   = rc_inv;
            state_d = S_MUL;
          end
        end else if (timer_last) begin
          res_d    = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_OUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_MUL: begin
        res_d    = mul_q;
        status_d = mul_status;
        state_d  = S_OUT;
      end

      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      den_q    <= '0;
      inv_q    <= '0;
      timer_q  <= '0;
      res_q    <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      den_q    <= den_d;
      inv_q    <= inv_d;
      timer_q  <= timer_d;
      res_q    <= res_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_recip_scale.sv
// -----------------------------------------------------------------------------
// tb_recip_scale
//   Directed and randomized bench for recip_scale. The reciprocal unit is a
//   stub driven from the main sequence; expected quotients come from a
//   plain-arithmetic model of "round(num * inv / 2^F), then saturate".
// -----------------------------------------------------------------------------
module tb_recip_scale;

  localparam int W  = 32;
  localparam int F  = 16;
  localparam int TO = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_num;
  logic [W-1:0] in_den;
  logic         rc_start;
  logic [W-1:0] rc_x;
  logic         rc_done;
  logic [W-1:0] rc_inv;
  logic         rc_invalid;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic [1:0]   out_status;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  recip_scale #(.W(W), .F(F), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_num     (in_num),
    .in_den     (in_den),
    .rc_start   (rc_start),
    .rc_x       (rc_x),
    .rc_done    (rc_done),
    .rc_inv     (rc_inv),
    .rc_invalid (rc_invalid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_q      (out_q),
    .out_status (out_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: quotient = floor(num*inv/2^F + 1/2), clamped to the signed range.
  function automatic logic [33:0] model(input logic [31:0] num, input logic [31:0] inv);
    longint p;
    longint r;
    p = longint'($signed(num)) * longint'({32'd0, inv});
    r = (p + 64'sd32768) >>> F;
    if (r > 64'sd2147483647)  return {2'd3, 32'h7FFF_FFFF};
    if (r < -64'sd2147483648) return {2'd3, 32'h8000_0000};
    return {2'd0, r[31:0]};
  endfunction

  task automatic send(input string tag, input logic [W-1:0] num, input logic [W-1:0] den);
    for (int i = 0; i < 100 && !in_ready; i++) tick();
    check({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_num   = num;
    in_den   = den;
    tick();
    in_valid = 1'b0;
    in_num   = $urandom;
    in_den   = $urandom;
  endtask

  // Stub reciprocal unit: done arrives `delay` cycles after the start cycle.
  task automatic stub(input int delay, input logic [W-1:0] inv, input logic invalid);
    repeat (delay) tick();
    rc_done    = 1'b1;
    rc_inv     = inv;
    rc_invalid = invalid;
    tick();
    rc_done    = 1'b0;
    rc_invalid = 1'b0;
    rc_inv     = 32'hDEAD_BEEF;
  endtask

  task automatic consume(input string tag, input logic [W-1:0] q, input logic [1:0] st);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".out_q"}, out_q, q);
    check({tag, ".out_status"}, out_status, st);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  // Full request through the reciprocal unit, with latency checks.
  task automatic run_mul(input string tag, input logic [W-1:0] num, input logic [W-1:0] den,
                         input logic [W-1:0] inv, input int delay,
                         input logic [W-1:0] exp_q, input logic [1:0] exp_st);
    send(tag, num, den);
    check({tag, ".rc_start"}, rc_start, 1);
    check({tag, ".rc_x"}, rc_x, den);
    stub(delay, inv, 1'b0);
    check({tag, ".valid_lat1"}, out_valid, 0);
    tick();
    consume(tag, exp_q, exp_st);
  endtask

  initial begin
    logic [33:0]  m;
    logic [W-1:0] r_num, r_den, r_inv;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_num     = '0;
    in_den     = '0;
    rc_done    = 1'b0;
    rc_inv     = '0;
    rc_invalid = 1'b0;
    out_ready  = 1'b0;
    #2;
    check("reset.outputs", {in_ready, out_valid, rc_start}, 3'b100);
    check("reset.out_q", out_q, 0);
    check("reset.out_status", out_status, 0);
    check("reset.rc_x", rc_x, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 3.0 / 2.0 with inv = 0.5; done 10 cycles after start.
    run_mul("basic", 32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 10, 32'h0001_8000, 2'd0);

    // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds up to zero.
    run_mul("round_pos", 32'h0000_0001, 32'h0002_0000, 32'h0000_8000, 3, 32'h0000_0001, 2'd0);
    run_mul("round_neg", 32'hFFFF_FFFF, 32'h0002_0000, 32'h0000_8000, 3, 32'h0000_0000, 2'd0);

    // Saturation both ways.
    run_mul("sat_pos", 32'h7FFF_0000, 32'h0000_8000, 32'h0002_0000, 2, 32'h7FFF_FFFF, 2'd3);
    run_mul("sat_neg", 32'h8001_0000, 32'h0000_8000, 32'h0002_0000, 2, 32'h8000_0000, 2'd3);

    // Non-positive denominators bypass the reciprocal unit.
    send("den_zero", 32'h0001_0000, 32'h0000_0000);
    check("den_zero.no_start", rc_start, 0);
    consume("den_zero", 32'h0, 2'd1);
    send("den_neg", 32'h0001_0000, 32'hFFFF_0000);
    check("den_neg.no_start", rc_start, 0);
    consume("den_neg", 32'h0, 2'd1);

    // Reciprocal unit rejects the operand.
    send("rc_invalid", 32'h0001_0000, 32'h0000_0001);
    check("rc_invalid.rc_start", rc_start, 1);
    stub(4, 32'h1234_5678, 1'b1);
    consume("rc_invalid", 32'h0, 2'd1);

    // No done at all: timeout after exactly TO cycles in WAIT.
    send("timeout", 32'h0001_0000, 32'h0001_0000);
    check("timeout.rc_start", rc_start, 1);
    repeat (TO) tick();
    check("timeout.not_yet", out_valid, 0);
    check("timeout.rc_x", rc_x, 32'h0001_0000);
    tick();
    consume("timeout", 32'h0, 2'd2);

    // Done on the final WAIT cycle still yields a normal result.
    run_mul("late_done", 32'h0003_0000, 32'h0002_0000, 32'h0000_8000, TO, 32'h0001_8000, 2'd0);

    // Back-pressure: output held, no new request accepted.
    send("hold", 32'h0003_0000, 32'h0002_0000);
    stub(5, 32'h0000_8000, 1'b0);
    tick();
    in_valid = 1'b1;
    in_num   = 32'h0000_0000;
    in_den   = 32'h0000_0000;
    for (int i = 0; i < 20; i++) begin
      check("hold.valid_ready", {out_valid, in_ready}, 2'b10);
      check("hold.out_q", out_q, 32'h0001_8000);
      check("hold.status", out_status, 0);
      tick();
    end
    in_valid = 1'b0;
    consume("hold", 32'h0001_8000, 2'd0);
    tick();
    check("hold.no_extra", out_valid, 0);

    // Asynchronous reset in the middle of WAIT.
    send("rst_wait", 32'h0003_0000, 32'h0002_0000);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_wait.strobes", {in_ready, out_valid, rc_start}, 3'b100);
    check("rst_wait.out_q", out_q, 0);
    check("rst_wait.status", out_status, 0);
    check("rst_wait.rc_x", rc_x, 0);
    tick();
    rst_n = 1'b1;
    rc_done = 1'b1;
    rc_inv  = 32'h0000_8000;
    tick();
    rc_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_wait.stray_done", {out_valid, rc_start, in_ready}, 3'b001);
      tick();
    end

    // Randomized requests against the model.
    for (int n = 0; n < 40; n++) begin
      r_num = $urandom;
      if (n % 3 == 0) r_num = r_num >>> $urandom_range(20, 0);
      r_den = $urandom;
      r_den[W-1] = 1'b0;
      r_den[0]   = 1'b1;
      r_inv = $urandom;
      r_inv = r_inv >> $urandom_range(24, 0);
      m = model(r_num, r_inv);
      run_mul($sformatf("rand%0d", n), r_num, r_den, r_inv, $urandom_range(20, 1),
              m[31:0], m[33:32]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
